regfile: RTL and testbench
==========================

# regfile

- 32 x 32-bit integer register file for the pipeline core.
- Consumes the write-back word `wD` from the write-back select mux, together with the WB-stage destination index and write enable.
- Serves two combinational read ports to the ID stage.
- Emits a registered write-back trace for the difftest/trace checker.

## Interface
Parameters:
- `AW`, 5, register index width (32 registers)
- `DW`, 32, data width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `rR1`  in  AW  read index, port 1 (ID stage rs1)
- `rR2`  in  AW  read index, port 2 (ID stage rs2)
- `rD1`  out  DW  read data, port 1
- `rD2`  out  DW  read data, port 2
- `we`  in  1  write enable from WB stage
- `wR`  in  AW  write index from WB stage
- `wD`  in  DW  write data (output of write-back select mux)
- `wb_pc`  in  DW  PC of the WB-stage instruction, trace only
- `dbg_wb_ena`  out  1  registered: a real write committed last cycle
- `dbg_wb_reg`  out  AW  registered destination of that write
- `dbg_wb_value`  out  DW  registered value of that write
- `dbg_wb_pc`  out  DW  registered PC of that write

## Operation
- Storage: 32 entries `x0..x31`. `x0` reads as 0 always and is never written.
- Write rule: on a rising edge with `rst`=0, `we`=1 and `wR`!=0, entry `wR` <= `wD`. In every other case storage holds.
- Read: `rDn` is combinational from `rRn`. `rRn`=0 gives 0 regardless of storage or bypass.
- Both read ports may address the same register and each returns the same value.
- Trace: the `dbg_*` registers load every cycle.
  - `dbg_wb_ena` <= `we && (wR!=0)`.
  - `dbg_wb_reg`, `dbg_wb_value` and `dbg_wb_pc` <= `wR`, `wD` and `wb_pc` when that qualifier is 1; otherwise they hold their previous values.
- Writes to `x0` with `we`=1 are dropped and do not raise `dbg_wb_ena`.

## Timing
- Reset, on a rising edge with `rst`=1:
  - All 32 entries clear to 0. Clearing all entries, not only `x0`, is required so the bench is deterministic.
  - `dbg_wb_ena`=0, `dbg_wb_reg`=0, `dbg_wb_value`=0, `dbg_wb_pc`=0.
- Reset overrides a simultaneous write. A write presented in the reset cycle is lost.
- Reset asserted mid-program clears state on that edge. The first post-reset write lands on the first edge where `rst`=0.
- Write latency: 1 edge. Without bypass, a read of the same index in the write cycle returns the old value, and the new value from the next cycle.
- Read latency: 0 cycles (combinational). The path is `rR` -> mux -> `rD` with no registering.
- Trace latency: `dbg_*` reflects the WB-stage write exactly 1 cycle after the write edge.
- No handshake. The WB stage qualifies `we`, and bubbles arrive with `we`=0.

## Configuration
- `RF_BYPASS_EN` defined: write-through forwarding.
  - If `we`=1, `wR`!=0 and `wR`==`rRn`, then `rDn`=`wD` in the same cycle.
  - This removes the WB->ID hazard, so the hazard unit need not stall for a distance-3 RAW.
- `RF_BYPASS_EN` undefined: reads return stored contents only.
  - The hazard unit must cover the distance-3 RAW hazard.
- The `x0`-reads-zero rule takes priority in both builds.

## Structure
- The widths `AW`/`DW` defaults and the register count (32) belong in the shared defines header, alongside the write-back select codes (`RF_ALU_C`, `RF_NPC_PC4`, `RF_DRAM_RD`).
- `RF_BYPASS_EN` is defined, or not, in that header.
- Sub-module: `rf_read_port`, instantiated twice. It is the combinational read mux with the `x0` and bypass logic, parameterised by `AW`/`DW`.

## Test plan
- Reset then read all 32 indices on both ports -> every `rD`=0; all `dbg_*`=0.
- Write `x5`=0xDEADBEEF, then on the next cycle set `rR1`=5 and `rR2`=5 -> both ports read 0xDEADBEEF. One cycle after the write: `dbg_wb_ena`=1, `dbg_wb_reg`=5, `dbg_wb_value`=0xDEADBEEF.
- Write `x0`=0x12345678 with `we`=1 -> `rR1`=0 reads 0 and `dbg_wb_ena`=0.
- Same-cycle write `x7`=0xA5A5A5A5 and read `rR1`=7, where `x7` previously held 0x11 -> `rD1`=0xA5A5A5A5 with `RF_BYPASS_EN`, 0x11 without. The next cycle reads 0xA5A5A5A5 in both builds.
- Write `x3`=1, `x4`=2, then assert `rst` in the same cycle as a write of `x4`=9 -> after the reset edge `x3`=0 and `x4`=0. The first post-reset write of `x4`=9 reads back 9.
- Back-to-back writes of `x10`=1, 2, 3 on consecutive cycles with `we` toggled off in the middle cycle (`wD`=2 dropped) -> the final read is 3. `dbg_wb_ena` sequence is 1,0,1, and `dbg_wb_value` holds 1 during the bubble.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_pkg: shared register-file widths and write-back select codes.   |
// | Optional build macro RF_BYPASS_EN (write-through forwarding); off here. |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
package regfile_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  typedef enum logic [1:0] {
    RF_ALU_C   = 2'd0,
    RF_NPC_PC4 = 2'd1,
    RF_DRAM_RD = 2'd2
  } rf_wb_sel_e;

  // True when a write-back really commits: enabled and not aimed at x0.
  function automatic logic rf_commit(input logic we, input logic [RF_AW-1:0] idx);
    return we && (idx != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_read_port: combinational read mux with x0-zero and optional bypass.  |
// | Forwarding compiled in only when RF_BYPASS_EN is defined. Rev 1.0       |
// +--------------------------------------------------------------------------+
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic [(1<<AW)-1:0][DW-1:0] mem,
  input  logic [AW-1:0]              raddr,
  input  logic                       we,
  input  logic [AW-1:0]              wr,
  input  logic [DW-1:0]              wd,
  output logic [DW-1:0]              rdata
);

  logic w_hit;

`ifdef RF_BYPASS_EN
  assign w_hit = we && (wr != '0) && (wr == raddr);
`else
  assign w_hit = 1'b0;
  logic w_unused;
  assign w_unused = ^{we, wr, wd};
`endif

  // x0 check sits first so it overrides both storage and forwarding.
  always_comb begin
    rdata = mem[raddr];
    if (raddr == '0)
      rdata = '0;
    else if (w_hit)
      rdata = wd;
  end

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile: 32x32 integer register file, two read ports, WB trace regs.    |
// | Build option RF_BYPASS_EN enables write-through forwarding. Rev 1.0     |
// +--------------------------------------------------------------------------+
module regfile
  import regfile_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rR1,
  input  logic [AW-1:0] rR2,
  output logic [DW-1:0] rD1,
  output logic [DW-1:0] rD2,
  input  logic          we,
  input  logic [AW-1:0] wR,
  input  logic [DW-1:0] wD,
  input  logic [DW-1:0] wb_pc,
  output logic          dbg_wb_ena,
  output logic [AW-1:0] dbg_wb_reg,
  output logic [DW-1:0] dbg_wb_value,
  output logic [DW-1:0] dbg_wb_pc
);

  localparam int C_NREG = 1 << AW;

  logic [C_NREG-1:0][DW-1:0] r_mem;
  logic                      w_commit;

  assign w_commit = rf_commit(we, wR);

  // Every entry clears on reset so post-reset reads are deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else if (w_commit) begin
      r_mem[wR] <= wD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_wb_ena   <= 1'b0;
      dbg_wb_reg   <= '0;
      dbg_wb_value <= '0;
      dbg_wb_pc    <= '0;
    end else begin
      dbg_wb_ena <= w_commit;
      if (w_commit) begin
        dbg_wb_reg   <= wR;
        dbg_wb_value <= wD;
        dbg_wb_pc    <= wb_pc;
      end
    end
  end

  rf_read_port #(.AW(AW), .DW(DW)) u_rp1 (
    .mem   (r_mem),
    .raddr (rR1),
    .we    (we),
    .wr    (wR),
    .wd    (wD),
    .rdata (rD1)
  );

  rf_read_port #(.AW(AW), .DW(DW)) u_rp2 (
    .mem   (r_mem),
    .raddr (rR2),
    .we    (we),
    .wr    (wR),
    .wd    (wD),
    .rdata (rD2)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile: directed self-checking bench for regfile. Rev 1.0           |
// +--------------------------------------------------------------------------+
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rR1, rR2, wR;
  logic [31:0] rD1, rD2, wD, wb_pc;
  logic        we;
  logic        dbg_wb_ena;
  logic [4:0]  dbg_wb_reg;
  logic [31:0] dbg_wb_value, dbg_wb_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk          (clk),
    .rst          (rst),
    .rR1          (rR1),
    .rR2          (rR2),
    .rD1          (rD1),
    .rD2          (rD2),
    .we           (we),
    .wR           (wR),
    .wD           (wD),
    .wb_pc        (wb_pc),
    .dbg_wb_ena   (dbg_wb_ena),
    .dbg_wb_reg   (dbg_wb_reg),
    .dbg_wb_value (dbg_wb_value),
    .dbg_wb_pc    (dbg_wb_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data, input logic [31:0] pc);
    we = 1'b1; wR = idx; wD = data; wb_pc = pc;
    tick();
    we = 1'b0;
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst = 1'b1; we = 1'b0; wR = '0; wD = '0; wb_pc = '0; rR1 = '0; rR2 = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset: all entries and trace registers are zero.
    for (int i = 0; i < 32; i++) begin
      rR1 = 5'(i); rR2 = 5'(31 - i);
      #1;
      chk("rst_rd1", rD1, 32'h0);
      chk("rst_rd2", rD2, 32'h0);
    end
    chk("rst_ena", {31'h0, dbg_wb_ena}, 32'h0);
    chk("rst_reg", {27'h0, dbg_wb_reg}, 32'h0);
    chk("rst_val", dbg_wb_value, 32'h0);
    chk("rst_pc",  dbg_wb_pc, 32'h0);

    // Basic write and dual-port read of the same index.
    wr(5'd5, 32'hDEADBEEF, 32'h0000_0100);
    chk("x5_ena", {31'h0, dbg_wb_ena}, 32'h1);
    chk("x5_reg", {27'h0, dbg_wb_reg}, 32'd5);
    chk("x5_val", dbg_wb_value, 32'hDEADBEEF);
    chk("x5_pc",  dbg_wb_pc, 32'h0000_0100);
    rR1 = 5'd5; rR2 = 5'd5; #1;
    chk("x5_rd1", rD1, 32'hDEADBEEF);
    chk("x5_rd2", rD2, 32'hDEADBEEF);

    // Write to x0 is dropped and does not raise the trace; trace fields hold.
    wr(5'd0, 32'h12345678, 32'h0000_0104);
    chk("x0_ena", {31'h0, dbg_wb_ena}, 32'h0);
    chk("x0_reg_hold", {27'h0, dbg_wb_reg}, 32'd5);
    chk("x0_val_hold", dbg_wb_value, 32'hDEADBEEF);
    rR1 = 5'd0; #1;
    chk("x0_rd1", rD1, 32'h0);

    // Same-cycle write/read of x7; x0 on port 2 while a write is active.
    wr(5'd7, 32'h0000_0011, 32'h0000_0108);
`ifdef RF_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h0000_0011;
`endif
    we = 1'b1; wR = 5'd7; wD = 32'hA5A5A5A5; wb_pc = 32'h0000_010C;
    rR1 = 5'd7; rR2 = 5'd0; #1;
    chk("x7_same", rD1, exp_byp);
    chk("x7_x0", rD2, 32'h0);
    tick();
    we = 1'b0; #1;
    chk("x7_next", rD1, 32'hA5A5A5A5);

    // Reset overrides a simultaneous write and clears every entry.
    wr(5'd3, 32'd1, 32'h0000_0110);
    wr(5'd4, 32'd2, 32'h0000_0114);
    rR1 = 5'd3; rR2 = 5'd4; #1;
    chk("pre_x3", rD1, 32'd1);
    chk("pre_x4", rD2, 32'd2);
    rst = 1'b1;
    wr(5'd4, 32'd9, 32'h0000_0118);
    rst = 1'b0; #1;
    chk("rst_x3", rD1, 32'h0);
    chk("rst_x4", rD2, 32'h0);
    chk("rst2_ena", {31'h0, dbg_wb_ena}, 32'h0);
    chk("rst2_reg", {27'h0, dbg_wb_reg}, 32'h0);
    chk("rst2_val", dbg_wb_value, 32'h0);
    rR1 = 5'd7; #1;
    chk("rst_x7", rD1, 32'h0);
    wr(5'd4, 32'd9, 32'h0000_011C);
    rR2 = 5'd4; #1;
    chk("post_x4", rD2, 32'd9);

    // Back-to-back writes with a bubble in the middle.
    wr(5'd10, 32'd1, 32'h0000_0120);
    chk("b2b_ena0", {31'h0, dbg_wb_ena}, 32'h1);
    chk("b2b_val0", dbg_wb_value, 32'd1);
    we = 1'b0; wR = 5'd10; wD = 32'd2; wb_pc = 32'h0000_0124;
    tick();
    chk("b2b_ena1", {31'h0, dbg_wb_ena}, 32'h0);
    chk("b2b_val1", dbg_wb_value, 32'd1);
    chk("b2b_pc1",  dbg_wb_pc, 32'h0000_0120);
    rR1 = 5'd10; #1;
    chk("b2b_mid", rD1, 32'd1);
    wr(5'd10, 32'd3, 32'h0000_0128);
    chk("b2b_ena2", {31'h0, dbg_wb_ena}, 32'h1);
    chk("b2b_val2", dbg_wb_value, 32'd3);
    chk("b2b_reg2", {27'h0, dbg_wb_reg}, 32'd10);
    #1;
    chk("b2b_rd", rD1, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
